bus_arbiter_2dev: RTL and testbench
===================================

Name: bus_arbiter_2dev

Overview:
Two-requester bus arbiter that sits directly upstream of the shared-bus multiplexer and generates its `sel`. Devices raise `req_x` and drive their data once `gnt_x` is high. The block gives round-robin fairness and a bounded hold time, so one device cannot starve the other. All outputs are registered (Moore), which keeps `sel` glitch-free on the bus.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one device keeps the grant while the other is requesting; must be >= 2.
- CNT_W, $clog2(MAX_HOLD), width of the hold counter; derived localparam, not user-set.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_1  input  1  device 1 requests the bus; level, held while it needs the bus.
- req_2  input  1  device 2 requests the bus.
- gnt_1  output  1  device 1 owns the bus.
- gnt_2  output  1  device 2 owns the bus.
- sel  output  1  mux select: 0 = device 1 drives, 1 = device 2 drives.
- bus_busy  output  1  gnt_1 | gnt_2.
- force_rel  output  1  one-cycle pulse: the grant was taken by timeout while the owner still requested.

Behaviour:
- Clock and reset are fixed: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- Reset (asynchronous, takes effect with no clock edge):
  - state = IDLE.
  - gnt_1 = gnt_2 = sel = bus_busy = force_rel = 0.
  - hold_cnt = 0.
  - last_owner = 2, so device 1 wins the first tie.
- States: IDLE, OWN1, OWN2.
  - gnt_1 = (state == OWN1); gnt_2 = (state == OWN2).
  - sel = 1 only in OWN2; sel = 0 in IDLE and OWN1.
- Latency: a request sampled at edge t produces its grant visible after edge t (one cycle). A deasserted request removes the grant after the next edge.
- IDLE transitions:
  - req_1 only -> OWN1.
  - req_2 only -> OWN2.
  - Both -> the device that is not last_owner.
  - Neither -> stay in IDLE.
- OWNx:
  - hold_cnt clears to 0 on entry and increments each cycle, saturating at MAX_HOLD-1.
  - Leave when req_x is low: go to OWNy if req_y is high, else IDLE. No idle gap.
  - Leave when hold_cnt == MAX_HOLD-1 and req_y is high: go to OWNy and assert force_rel for one cycle. A grant therefore lasts at most MAX_HOLD cycles under contention.
  - Hold expiry with req_y low: stay in OWNx; the counter stays saturated. Release happens on the first later cycle in which req_y is high.
  - req_x drop coinciding with expiry: go to OWNy; force_rel = 0, because the release was voluntary.
- last_owner updates on every entry into OWN1 or OWN2.
- Both grants are never high in the same cycle (invariant).
- A requester that drops its request and re-raises it in the next cycle re-enters arbitration normally.

Optional Feature:
- Macro: BUS_ARB_TURNAROUND_EN.
- Defined:
  - Adds a TURN state. Every OWNx -> OWNy handover passes through exactly one TURN cycle with gnt_1 = gnt_2 = 0 and bus_busy = 0.
  - sel holds its previous value during TURN, giving the bus a dead cycle.
  - TURN exit follows the IDLE rules using the updated last_owner.
  - force_rel pulses in the TURN cycle.
- Undefined: direct switch as described in Behaviour; the TURN state does not exist.

Decomposition:
- Package bus_arb_pkg holds:
  - State encoding localparams: IDLE, OWN1, OWN2, TURN.
  - Owner id constants.
  - The MAX_HOLD minimum check.
- Sub-module bus_arb_hold_cnt: saturating counter with clear, enable and a `expired` flag. It is instantiated once.

Test Plan:
1. Hold rst_n = 0, then release with both requests low for 5 cycles -> all outputs stay 0; state = IDLE.
2. req_1 = 1 at edge 2, dropped at edge 6 -> gnt_1 high from edge 2 to edge 6, sel = 0, bus_busy follows gnt_1, force_rel = 0.
3. req_1 and req_2 both raised in the same cycle after reset -> gnt_1 first. When req_1 drops, gnt_2 rises on the next edge, sel = 1, with no idle cycle.
4. MAX_HOLD = 4, req_1 held high, req_2 raised during OWN1 -> gnt_1 lasts exactly 4 cycles, then gnt_2 rises, force_rel pulses once and sel = 1. Both requests held continuously -> grants alternate 4/4.
5. In OWN2 with sel = 1, pull rst_n low between clock edges -> gnt_2, sel and bus_busy go to 0 immediately. After release, IDLE arbitration resumes.
6. With BUS_ARB_TURNAROUND_EN defined, repeat test 3 -> exactly one cycle with both grants 0 and sel still 0, then gnt_2 = 1 and sel = 1.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the two-device bus arbiter.
// State encoding, owner ids, the MAX_HOLD lower bound and the tie-break rule live here.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2,
    TURN = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_1 = 1'b0,
    OWNER_2 = 1'b1
  } owner_e;

  localparam int unsigned MAX_HOLD_MIN = 2;

  function automatic bit max_hold_ok(input int unsigned max_hold);
    return max_hold >= MAX_HOLD_MIN;
  endfunction

  // Idle-style arbitration: a tie goes to the device that did not own the bus last.
  function automatic arb_state_e arbitrate(input logic r1, input logic r2, input owner_e last);
    arb_state_e nxt;
    nxt = IDLE;
    if (r1 && r2) begin
      nxt = (last == OWNER_1) ? OWN2 : OWN1;
    end else if (r1) begin
      nxt = OWN1;
    end else if (r2) begin
      nxt = OWN2;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bus_arb_hold_cnt.sv
// Saturating hold counter for the arbiter; expired_o flags that the owner
// has used its full MAX_HOLD-cycle slot.
module bus_arb_hold_cnt #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/bus_arbiter_2dev.sv
// Round-robin two-device bus arbiter with bounded hold time and registered outputs.
// Optional BUS_ARB_TURNAROUND_EN inserts one dead TURN cycle on every handover.
module bus_arbiter_2dev
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_1,
  input  logic req_2,
  output logic gnt_1,
  output logic gnt_2,
  output logic sel,
  output logic bus_busy,
  output logic force_rel
);

  localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  if (!max_hold_ok(MAX_HOLD)) begin : g_bad_max_hold
    $error("bus_arbiter_2dev: MAX_HOLD must be >= 2");
  end

`ifdef BUS_ARB_TURNAROUND_EN
  localparam arb_state_e TO_OWN1 = TURN;
  localparam arb_state_e TO_OWN2 = TURN;
`else
  localparam arb_state_e TO_OWN1 = OWN1;
  localparam arb_state_e TO_OWN2 = OWN2;
`endif

  arb_state_e state_q, state_d;
  owner_e     last_owner_q, last_owner_d;
  logic       gnt_1_q, gnt_1_d;
  logic       gnt_2_q, gnt_2_d;
  logic       sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       force_q, force_d;
  logic       entry_own;
  logic       expired;

  // Next state, handover decisions and next registered outputs.
  always_comb begin
    state_d      = state_q;
    force_d      = 1'b0;
    last_owner_d = last_owner_q;

    case (state_q)
      IDLE: state_d = arbitrate(req_1, req_2, last_owner_q);
      OWN1: begin
        if (!req_1) begin
          state_d = req_2 ? TO_OWN2 : IDLE;
        end else if (expired && req_2) begin
          state_d = TO_OWN2;
          force_d = 1'b1;
        end
      end
      OWN2: begin
        if (!req_2) begin
          state_d = req_1 ? TO_OWN1 : IDLE;
        end else if (expired && req_1) begin
          state_d = TO_OWN1;
          force_d = 1'b1;
        end
      end
      TURN: begin
`ifdef BUS_ARB_TURNAROUND_EN
        state_d = arbitrate(req_1, req_2, last_owner_q);
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    entry_own = ((state_d == OWN1) && (state_q != OWN1)) ||
                ((state_d == OWN2) && (state_q != OWN2));
    if (entry_own) begin
      last_owner_d = (state_d == OWN1) ? OWNER_1 : OWNER_2;
    end

    gnt_1_d = (state_d == OWN1);
    gnt_2_d = (state_d == OWN2);
    busy_d  = gnt_1_d | gnt_2_d;
    sel_d   = (state_d == OWN2) || ((state_d == TURN) && sel_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_2;
      gnt_1_q      <= 1'b0;
      gnt_2_q      <= 1'b0;
      sel_q        <= 1'b0;
      busy_q       <= 1'b0;
      force_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      gnt_1_q      <= gnt_1_d;
      gnt_2_q      <= gnt_2_d;
      sel_q        <= sel_d;
      busy_q       <= busy_d;
      force_q      <= force_d;
    end
  end

  bus_arb_hold_cnt #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_hold_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (entry_own),
    .en_i      ((state_q == OWN1) || (state_q == OWN2)),
    .expired_o (expired)
  );

  assign gnt_1     = gnt_1_q;
  assign gnt_2     = gnt_2_q;
  assign sel       = sel_q;
  assign bus_busy  = busy_q;
  assign force_rel = force_q;

endmodule

// File: tb/tb_bus_arbiter_2dev.sv
// Directed self-checking bench for bus_arbiter_2dev with MAX_HOLD = 4.
// Output vector order: {gnt_1, gnt_2, sel, bus_busy, force_rel}.
module tb_bus_arbiter_2dev;

  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_G1    = 5'b10010;
  localparam logic [4:0] O_G1F   = 5'b10011;
  localparam logic [4:0] O_G2    = 5'b01110;
  localparam logic [4:0] O_G2F   = 5'b01111;
  localparam logic [4:0] O_T0F   = 5'b00001;
  localparam logic [4:0] O_T1F   = 5'b00101;

  logic clk = 1'b0;
  logic rst_n;
  logic req_1, req_2;
  logic gnt_1, gnt_2, sel, bus_busy, force_rel;

  int n_cmp = 0;
  int n_err = 0;

  bus_arbiter_2dev #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_1     (req_1),
    .req_2     (req_2),
    .gnt_1     (gnt_1),
    .gnt_2     (gnt_2),
    .sel       (sel),
    .bus_busy  (bus_busy),
    .force_rel (force_rel)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {gnt_1, gnt_2, sel, bus_busy, force_rel};
  endfunction

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_1 = 1'b0;
    req_2 = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("reset_async", outs(), O_IDLE);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_seq(input string tag, input logic [4:0] seq [$]);
    foreach (seq[i]) begin
      tick();
      check(tag, outs(), seq[i]);
    end
  endtask

  // Both grants must never be high together.
  always @(negedge clk) begin
    if (rst_n === 1'b1) check("mutex", {4'b0, gnt_1 & gnt_2}, 5'b0);
  end

  initial begin
    logic [4:0] seq [$];
    rst_n = 1'b1;
    req_1 = 1'b0;
    req_2 = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("reset_state", outs(), O_IDLE);
    tick();
    tick();
    rst_n = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_quiet", outs(), O_IDLE);
    end

    // Single requester: grant one cycle after request, drop one cycle after release.
    req_1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("single_own1", outs(), O_G1);
    end
    req_1 = 1'b0;
    tick();
    check("single_release", outs(), O_IDLE);

    // Tie after reset goes to device 1; voluntary handover.
    do_reset();
    req_1 = 1'b1;
    req_2 = 1'b1;
    tick();
    check("tie_first", outs(), O_G1);
    tick();
    check("tie_hold", outs(), O_G1);
    req_1 = 1'b0;
`ifdef BUS_ARB_TURNAROUND_EN
    seq = '{O_IDLE, O_G2};
`else
    seq = '{O_G2};
`endif
    run_seq("handover_vol", seq);
    req_2 = 1'b0;
    tick();
    check("handover_idle", outs(), O_IDLE);

    // Hold timeout under contention, then continuous alternation.
    do_reset();
    req_1 = 1'b1;
    tick();
    check("hold_c1", outs(), O_G1);
    req_2 = 1'b1;
`ifdef BUS_ARB_TURNAROUND_EN
    seq = '{O_G1, O_G1, O_G1, O_T0F, O_G2, O_G2, O_G2, O_G2, O_T1F,
            O_G1, O_G1, O_G1, O_G1, O_T0F};
`else
    seq = '{O_G1, O_G1, O_G1, O_G2F, O_G2, O_G2, O_G2,
            O_G1F, O_G1, O_G1, O_G1, O_G2F};
`endif
    run_seq("alternate", seq);

    // Saturated hold with no competitor, then late competitor forces release.
    do_reset();
    req_1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("saturate_own1", outs(), O_G1);
    end
    req_2 = 1'b1;
    tick();
`ifdef BUS_ARB_TURNAROUND_EN
    check("late_force", outs(), O_T0F);
`else
    check("late_force", outs(), O_G2F);
`endif

    // Voluntary drop at expiry: no force_rel.
    do_reset();
    req_1 = 1'b1;
    req_2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("expiry_own1", outs(), O_G1);
    end
    req_1 = 1'b0;
`ifdef BUS_ARB_TURNAROUND_EN
    seq = '{O_IDLE, O_G2};
`else
    seq = '{O_G2};
`endif
    run_seq("expiry_drop", seq);

    // Asynchronous reset in OWN2 clears outputs without a clock edge.
    #2 rst_n = 1'b0;
    #1 check("async_rst_own2", outs(), O_IDLE);
    #1 rst_n = 1'b1;
    req_1 = 1'b1;
    req_2 = 1'b1;
    tick();
    check("post_rst_tie", outs(), O_G1);

    // Drop and immediate re-raise re-arbitrates normally.
    req_2 = 1'b0;
    tick();
    check("reraise_pre", outs(), O_G1);
    req_1 = 1'b0;
    tick();
    check("reraise_drop", outs(), O_IDLE);
    req_1 = 1'b1;
    tick();
    check("reraise_gnt", outs(), O_G1);

    req_1 = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
